// File: rtl/sw_bounce_gen_if.sv
// Switch-emulator bus: clean level request in, bouncy switch level and event status out.
// The master drives the request; the slave (sw_bounce_gen) drives the emulated switch.
interface sw_bounce_gen_if;
  logic       level_req;
  logic       sw_out;
  logic       busy;
  logic       settled;
  logic [7:0] toggle_cnt;

  modport master (
    output level_req,
    input  sw_out,
    input  busy,
    input  settled,
    input  toggle_cnt
  );

  modport slave (
    input  level_req,
    output sw_out,
    output busy,
    output settled,
    output toggle_cnt
  );
endinterface

// File: rtl/sw_bounce_gen.sv
// Mechanical-switch emulator: a clean level change on level_req becomes a burst of
// pseudo-randomly spaced toggles that always ends at the requested level, then a stable hold.
module sw_bounce_gen #(
  parameter int unsigned N_BOUNCE = 2,
  parameter int unsigned GAP_W    = 3,
  parameter int unsigned HOLD_CYC = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  sw_bounce_gen_if.slave sw
);

  localparam int unsigned LEFT_W = $clog2(2 * N_BOUNCE + 2);
  localparam int unsigned GAP_CW = GAP_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [15:0] TAPS   = 16'hB400;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BOUNCE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]        state;
  logic              stable;
  logic              sw_out_q;
  logic              busy_q;
  logic              settled_q;
  logic [7:0]        toggle_cnt_q;
  logic [LEFT_W-1:0] left_cnt;
  logic [GAP_CW-1:0] gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic [GAP_CW-1:0] gap_seed;
  logic [7:0]        toggle_inc;

  assign lfsr_nxt   = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  // Gap between toggles spans 1..2^GAP_W cycles, drawn from the current LFSR value.
  assign gap_seed   = GAP_CW'(lfsr[GAP_W-1:0]) + GAP_CW'(1);
  assign toggle_inc = (toggle_cnt_q == 8'hFF) ? toggle_cnt_q : toggle_cnt_q + 8'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation/synthesis mismatch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      stable       <= 1'b0;
      sw_out_q     <= 1'b0;
      busy_q       <= 1'b0;
      settled_q    <= 1'b0;
      toggle_cnt_q <= 8'd0;
      left_cnt     <= '0;
      gap_cnt      <= '0;
      hold_cnt     <= '0;
      lfsr         <= SEED;
    end else begin
      lfsr      <= lfsr_nxt;
      settled_q <= 1'b0;
      case (state)
        S_IDLE: begin
          sw_out_q <= stable;
          if (sw.level_req != stable) begin
            stable       <= sw.level_req;
            sw_out_q     <= sw.level_req;
            toggle_cnt_q <= 8'd1;
            left_cnt     <= LEFT_W'(2 * N_BOUNCE);
            gap_cnt      <= gap_seed;
            state        <= S_BOUNCE;
            busy_q       <= 1'b1;
          end
        end
        S_BOUNCE: begin
          // left_cnt reaching zero means the last toggle already landed on the target level.
          if (left_cnt == '0) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_W'(HOLD_CYC);
          end else if (gap_cnt == GAP_CW'(1)) begin
            sw_out_q     <= ~sw_out_q;
            toggle_cnt_q <= toggle_inc;
            left_cnt     <= left_cnt - LEFT_W'(1);
            gap_cnt      <= gap_seed;
          end else begin
            gap_cnt <= gap_cnt - GAP_CW'(1);
          end
        end
        S_HOLD: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            settled_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          busy_q   <= 1'b0;
          sw_out_q <= stable;
        end
      endcase
    end
  end

  assign sw.sw_out     = sw_out_q;
  assign sw.busy       = busy_q;
  assign sw.settled    = settled_q;
  assign sw.toggle_cnt = toggle_cnt_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Scoreboarded bench for sw_bounce_gen: stimulus pushes expected events, monitors check
// toggle spacing against a reference LFSR, hold timing, final level and a loopback debouncer.
module tb_sw_bounce_gen;

  localparam int          HOLD = 8;
  localparam int          DB_N = 9;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic        level;
    int unsigned n;
  } exp_t;

  logic clk;
  logic reset_a;
  logic reset_b;

  sw_bounce_gen_if if_a ();
  sw_bounce_gen_if if_b ();

  sw_bounce_gen #(.N_BOUNCE(2), .GAP_W(3), .HOLD_CYC(HOLD), .SEED(SEED)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .sw    (if_a)
  );

  sw_bounce_gen #(.N_BOUNCE(0), .GAP_W(3), .HOLD_CYC(HOLD), .SEED(SEED)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .sw    (if_b)
  );

  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [15:0] m_lfsr_a;
  logic [15:0] prev_lfsr_a = SEED;
  logic        prev_sw_a   = 1'b0;
  logic        prev_sw_b   = 1'b0;
  int          cyc_a       = 0;
  int          cyc_b       = 0;
  int          tidx_a      = 0;
  int          tidx_b      = 0;
  int          toggles_a   = 0;
  int          toggles_b   = 0;
  int          last_tog_a  = 0;
  int          last_tog_b  = 0;
  int          pred_gap_a  = 0;
  logic        db          = 1'b0;
  int          db_cnt      = 0;
  int          db_rises    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference LFSR for the N_BOUNCE=2 instance, tracking its reset.
  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) m_lfsr_a <= SEED;
    else          m_lfsr_a <= lfsr_step(m_lfsr_a);
  end

  // Monitor A: toggle spacing, settled scoreboard, loopback debouncer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_a) begin
        tidx_a    = 0;
        prev_sw_a = 1'b0;
        db        = 1'b0;
        db_cnt    = 0;
      end else begin
        if (if_a.sw_out !== prev_sw_a) begin
          tidx_a++;
          toggles_a++;
          if (tidx_a > 1) check("gap_a", cyc_a - last_tog_a, pred_gap_a);
          pred_gap_a = 1 + int'(prev_lfsr_a[2:0]);
          last_tog_a = cyc_a;
          prev_sw_a  = if_a.sw_out;
        end
        if (if_a.settled) begin
          if (q_a.size() == 0) begin
            check("settled_unexpected_a", q_a.size(), 1);
          end else begin
            e = q_a.pop_front();
            check("settle_level_a", if_a.sw_out, e.level);
            check("settle_tcnt_a", if_a.toggle_cnt, e.n);
            check("settle_ntog_a", tidx_a, e.n);
            check("settle_hold_a", cyc_a - last_tog_a, HOLD + 1);
            check("settle_busy_a", if_a.busy, 0);
          end
          tidx_a = 0;
        end
        if (if_a.sw_out == db) begin
          db_cnt = 0;
        end else begin
          db_cnt++;
          if (db_cnt == DB_N) begin
            db     = if_a.sw_out;
            db_cnt = 0;
            if (db) db_rises++;
          end
        end
      end
      prev_lfsr_a = m_lfsr_a;
      cyc_a++;
    end
  end

  // Monitor B: settled scoreboard for the single-edge instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        tidx_b    = 0;
        prev_sw_b = 1'b0;
      end else begin
        if (if_b.sw_out !== prev_sw_b) begin
          tidx_b++;
          toggles_b++;
          last_tog_b = cyc_b;
          prev_sw_b  = if_b.sw_out;
        end
        if (if_b.settled) begin
          if (q_b.size() == 0) begin
            check("settled_unexpected_b", q_b.size(), 1);
          end else begin
            e = q_b.pop_front();
            check("settle_level_b", if_b.sw_out, e.level);
            check("settle_tcnt_b", if_b.toggle_cnt, e.n);
            check("settle_ntog_b", tidx_b, e.n);
            check("settle_hold_b", cyc_b - last_tog_b, HOLD + 1);
          end
          tidx_b = 0;
        end
      end
      cyc_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && !(q_a.size() == 0 && !if_a.busy); i++) tick();
    check("done_queue_a", q_a.size(), 0);
    check("done_busy_a", if_a.busy, 0);
  endtask

  task automatic wait_done_b(input int budget);
    for (int i = 0; i < budget && !(q_b.size() == 0 && !if_b.busy); i++) tick();
    check("done_queue_b", q_b.size(), 0);
    check("done_busy_b", if_b.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int snap;
    reset_a = 1'b0;
    reset_b = 1'b0;
    if_a.level_req = 1'b0;
    if_b.level_req = 1'b0;

    // Reset and quiet idle
    repeat (3) @(posedge clk);
    #2;
    reset_a = 1'b1;
    reset_b = 1'b1;
    tick();
    check("rst_sw_a", if_a.sw_out, 0);
    check("rst_busy_a", if_a.busy, 0);
    check("rst_settled_a", if_a.settled, 0);
    check("rst_tcnt_a", if_a.toggle_cnt, 0);
    check("rst_sw_b", if_b.sw_out, 0);
    repeat (50) tick();
    check("idle_toggles_a", toggles_a, 0);
    check("idle_toggles_b", toggles_b, 0);
    check("idle_busy_a", if_a.busy, 0);

    // Rising event, 5 toggles
    q_a.push_back('{level: 1'b1, n: 5});
    if_a.level_req = 1'b1;
    tick();
    check("lat_sw_a", if_a.sw_out, 1);
    check("lat_busy_a", if_a.busy, 1);
    check("lat_tcnt_a", if_a.toggle_cnt, 1);
    wait_done_a(200);
    check("rise_final_a", if_a.sw_out, 1);

    // Falling event
    q_a.push_back('{level: 1'b0, n: 5});
    if_a.level_req = 1'b0;
    tick();
    check("fall_lat_sw_a", if_a.sw_out, 0);
    wait_done_a(200);
    check("fall_tcnt_a", if_a.toggle_cnt, 5);

    // Request reversed during BOUNCE: finish at 1, then a new event to 0 right after HOLD
    q_a.push_back('{level: 1'b1, n: 5});
    q_a.push_back('{level: 1'b0, n: 5});
    if_a.level_req = 1'b1;
    tick();
    if_a.level_req = 1'b0;
    tick();
    check("rev_busy_a", if_a.busy, 1);
    for (int i = 0; i < 200 && !if_a.settled; i++) tick();
    check("rev_settled_a", if_a.settled, 1);
    check("rev_level_a", if_a.sw_out, 1);
    tick();
    check("rev_restart_sw_a", if_a.sw_out, 0);
    check("rev_restart_busy_a", if_a.busy, 1);
    check("rev_restart_tcnt_a", if_a.toggle_cnt, 1);
    wait_done_a(200);

    // Request pulsed away and back within HOLD only: no extra event
    q_a.push_back('{level: 1'b1, n: 5});
    if_a.level_req = 1'b1;
    tick();
    for (int i = 0; i < 100 && if_a.toggle_cnt != 8'd5; i++) tick();
    check("pulse_tcnt5_a", if_a.toggle_cnt, 5);
    tick();
    tick();
    check("pulse_hold_busy_a", if_a.busy, 1);
    if_a.level_req = 1'b0;
    tick();
    tick();
    if_a.level_req = 1'b1;
    wait_done_a(200);
    snap = toggles_a;
    repeat (30) tick();
    check("pulse_no_event_a", toggles_a, snap);
    check("pulse_tcnt_hold_a", if_a.toggle_cnt, 5);
    check("pulse_sw_a", if_a.sw_out, 1);

    // N_BOUNCE=0: single clean edge
    q_b.push_back('{level: 1'b1, n: 1});
    if_b.level_req = 1'b1;
    tick();
    check("nb0_sw_b", if_b.sw_out, 1);
    check("nb0_busy_b", if_b.busy, 1);
    check("nb0_tcnt_b", if_b.toggle_cnt, 1);
    wait_done_b(100);
    check("nb0_final_b", if_b.sw_out, 1);

    // Return A to 0, then reset mid-BOUNCE after toggle 3 and rerun the event
    q_a.push_back('{level: 1'b0, n: 5});
    if_a.level_req = 1'b0;
    tick();
    wait_done_a(200);
    if_a.level_req = 1'b1;
    tick();
    for (int i = 0; i < 100 && if_a.toggle_cnt != 8'd3; i++) tick();
    check("abort_tcnt3_a", if_a.toggle_cnt, 3);
    check("abort_sw_pre_a", if_a.sw_out, 1);
    reset_a = 1'b0;
    #1;
    check("abort_sw_a", if_a.sw_out, 0);
    check("abort_busy_a", if_a.busy, 0);
    check("abort_tcnt_a", if_a.toggle_cnt, 0);
    tick();
    tick();
    q_a.push_back('{level: 1'b1, n: 5});
    reset_a = 1'b1;
    tick();
    check("post_rst_sw_a", if_a.sw_out, 1);
    wait_done_a(200);
    check("db_rises_a", db_rises, 4);
    check("db_level_a", db, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
